mem_port_arbiter: RTL and testbench

Sequential arbiter that shares one single-ported, word-wide memory between the instruction-fetch path and the load/store data path of the RV32I core. It converts the control unit's `MemRdCtrl`/`MemWrCtrl` encodings into byte-enables, aligned write data and sign/zero-extended load results. It sits between the core (PC/fetch logic and the load/store datapath) and the memory model or bus bridge, and stalls either requester until its access completes.

---
 rtl/cpu_pkg.sv | 42 ++++
 rtl/mem_port_arbiter_if.sv | 47 ++++
 rtl/mem_port_arbiter_load_extend.sv | 36 +++
 rtl/mem_port_arbiter.sv | 191 +++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 276 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - Load/store control codes shared with the control unit, plus arbiter FSM state
package cpu_pkg;

    localparam logic [2:0] RD_NONE = 3'd0;
    localparam logic [2:0] RD_LB   = 3'd1;
    localparam logic [2:0] RD_LBU  = 3'd2;
    localparam logic [2:0] RD_LH   = 3'd3;
    localparam logic [2:0] RD_LHU  = 3'd4;
    localparam logic [2:0] RD_LW   = 3'd5;

    localparam logic [1:0] WR_NONE = 2'd0;
    localparam logic [1:0] WR_SB   = 2'd1;
    localparam logic [1:0] WR_SH   = 2'd2;
    localparam logic [1:0] WR_SW   = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_ISSUE    = 2'd1,
        ST_WAIT_RD  = 2'd2,
        ST_ERR_RESP = 2'd3
    } arb_state_t;

    function automatic logic [3:0] store_be(input logic [1:0] wr_ctrl, input logic [1:0] addr_lo);
        case (wr_ctrl)
            WR_SB:   store_be = 4'b0001 << addr_lo;
            WR_SH:   store_be = 4'b0011 << addr_lo;
            WR_SW:   store_be = 4'b1111;
            default: store_be = 4'b0000;
        endcase
    endfunction

    // Replicating the source bytes puts them on every lane; byte enables pick the live one.
    function automatic logic [31:0] store_data(input logic [1:0] wr_ctrl, input logic [31:0] wdata);
        case (wr_ctrl)
            WR_SB:   store_data = {4{wdata[7:0]}};
            WR_SH:   store_data = {2{wdata[15:0]}};
            WR_SW:   store_data = wdata;
            default: store_data = 32'h0;
        endcase
    endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - Fetch, data and memory-side signals of the shared memory port
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_ack;
    logic [31:0]       if_rdata;
    logic              if_err;

    logic              d_req;
    logic [ADDR_W-1:0] d_addr;
    logic [2:0]        d_rd_ctrl;
    logic [1:0]        d_wr_ctrl;
    logic [31:0]       d_wdata;
    logic              d_ack;
    logic [31:0]       d_rdata;
    logic              d_err;

    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [3:0]        mem_be;
    logic [31:0]       mem_wdata;
    logic              mem_gnt;
    logic              mem_rvalid;
    logic [31:0]       mem_rdata;

    modport slave (
        input  if_req, if_addr,
        output if_ack, if_rdata, if_err,
        input  d_req, d_addr, d_rd_ctrl, d_wr_ctrl, d_wdata,
        output d_ack, d_rdata, d_err,
        output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        input  mem_gnt, mem_rvalid, mem_rdata
    );

    modport master (
        output if_req, if_addr,
        input  if_ack, if_rdata, if_err,
        output d_req, d_addr, d_rd_ctrl, d_wr_ctrl, d_wdata,
        input  d_ack, d_rdata, d_err,
        input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        output mem_gnt, mem_rvalid, mem_rdata
    );

endinterface

// File: rtl/mem_port_arbiter_load_extend.sv
// rtl/mem_port_arbiter_load_extend.sv - Lane select and sign/zero extension of a loaded word
module load_extend
    import cpu_pkg::*;
(
    input  logic [31:0] i_word,
    input  logic [1:0]  i_addr_lo,
    input  logic [2:0]  i_rd_ctrl,
    output logic [31:0] o_data
);
    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte = i_word[7:0];
        case (i_addr_lo)
            2'd1:    w_byte = i_word[15:8];
            2'd2:    w_byte = i_word[23:16];
            2'd3:    w_byte = i_word[31:24];
            default: w_byte = i_word[7:0];
        endcase
        w_half = i_addr_lo[1] ? i_word[31:16] : i_word[15:0];
    end

    always_comb begin
        o_data = 32'h0;
        case (i_rd_ctrl)
            RD_LB:   o_data = {{24{w_byte[7]}}, w_byte};
            RD_LBU:  o_data = {24'h0, w_byte};
            RD_LH:   o_data = {{16{w_half[15]}}, w_half};
            RD_LHU:  o_data = {16'h0, w_half};
            RD_LW:   o_data = i_word;
            default: o_data = 32'h0;
        endcase
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - Round-robin arbiter sharing one word memory between fetch and load/store
module mem_port_arbiter
    import cpu_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    mem_port_arbiter_if.slave bus
);
    arb_state_t        r_state, w_state_nxt;
    logic              r_last_d, w_last_d_nxt;
    logic              r_owner_d, w_owner_d_nxt;
    logic              r_we, w_we_nxt;
    logic [1:0]        r_addr_lo, w_addr_lo_nxt;
    logic [2:0]        r_rd_ctrl, w_rd_ctrl_nxt;

    logic              r_mem_req, w_mem_req_nxt;
    logic              r_mem_we, w_mem_we_nxt;
    logic [ADDR_W-1:0] r_mem_addr, w_mem_addr_nxt;
    logic [3:0]        r_mem_be, w_mem_be_nxt;
    logic [31:0]       r_mem_wdata, w_mem_wdata_nxt;

    logic              r_if_ack, w_if_ack_nxt;
    logic [31:0]       r_if_rdata, w_if_rdata_nxt;
    logic              r_if_err, w_if_err_nxt;
    logic              r_d_ack, w_d_ack_nxt;
    logic [31:0]       r_d_rdata, w_d_rdata_nxt;
    logic              r_d_err, w_d_err_nxt;

    logic              w_if_pend, w_d_pend, w_grant_d;
    logic              w_if_bad, w_d_illegal, w_d_misalign, w_d_bad, w_sel_bad;
    logic              w_sel_we, w_wr_ack;
    logic [ADDR_W-1:0] w_sel_addr;
    logic [31:0]       w_load_data;

    // A read ack lands while the FSM is already back in IDLE and the requester still holds req;
    // masking it for that cycle keeps the finished access from being started again.
    assign w_if_pend = bus.if_req & ~r_if_ack;
    assign w_d_pend  = bus.d_req & ~r_d_ack;
    assign w_grant_d = w_d_pend & (~w_if_pend | ~r_last_d);

    assign w_if_bad     = (bus.if_addr[1:0] != 2'b00);
    assign w_d_illegal  = ((bus.d_rd_ctrl != RD_NONE) && (bus.d_wr_ctrl != WR_NONE))
                        || ((bus.d_rd_ctrl == RD_NONE) && (bus.d_wr_ctrl == WR_NONE))
                        || (bus.d_rd_ctrl > RD_LW);
    assign w_d_misalign = (((bus.d_rd_ctrl == RD_LH) || (bus.d_rd_ctrl == RD_LHU)
                            || (bus.d_wr_ctrl == WR_SH)) && bus.d_addr[0])
                        || (((bus.d_rd_ctrl == RD_LW) || (bus.d_wr_ctrl == WR_SW))
                            && (bus.d_addr[1:0] != 2'b00));
    assign w_d_bad      = w_d_illegal | w_d_misalign;
    assign w_sel_bad    = w_grant_d ? w_d_bad : w_if_bad;
    assign w_sel_addr   = w_grant_d ? bus.d_addr : bus.if_addr;
    assign w_sel_we     = w_grant_d & (bus.d_wr_ctrl != WR_NONE);
    assign w_wr_ack     = (r_state == ST_ISSUE) & bus.mem_gnt & r_we;

    load_extend u_load_extend (
        .i_word    (bus.mem_rdata),
        .i_addr_lo (r_addr_lo),
        .i_rd_ctrl (r_rd_ctrl),
        .o_data    (w_load_data)
    );

    always_comb begin
        w_state_nxt     = r_state;
        w_last_d_nxt    = r_last_d;
        w_owner_d_nxt   = r_owner_d;
        w_we_nxt        = r_we;
        w_addr_lo_nxt   = r_addr_lo;
        w_rd_ctrl_nxt   = r_rd_ctrl;
        w_mem_req_nxt   = r_mem_req;
        w_mem_we_nxt    = r_mem_we;
        w_mem_addr_nxt  = r_mem_addr;
        w_mem_be_nxt    = r_mem_be;
        w_mem_wdata_nxt = r_mem_wdata;
        w_if_ack_nxt    = 1'b0;
        w_if_rdata_nxt  = 32'h0;
        w_if_err_nxt    = 1'b0;
        w_d_ack_nxt     = 1'b0;
        w_d_rdata_nxt   = 32'h0;
        w_d_err_nxt     = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (w_if_pend || w_d_pend) begin
                    w_last_d_nxt  = w_grant_d;
                    w_owner_d_nxt = w_grant_d;
                    w_we_nxt      = w_sel_we;
                    w_addr_lo_nxt = w_sel_addr[1:0];
                    w_rd_ctrl_nxt = w_grant_d ? bus.d_rd_ctrl : RD_NONE;
                    if (w_sel_bad) begin
                        // Error ack is registered here so it shows in the ERR_RESP cycle.
                        w_state_nxt  = ST_ERR_RESP;
                        w_d_ack_nxt  = w_grant_d;
                        w_d_err_nxt  = w_grant_d;
                        w_if_ack_nxt = ~w_grant_d;
                        w_if_err_nxt = ~w_grant_d;
                    end else begin
                        w_state_nxt     = ST_ISSUE;
                        w_mem_req_nxt   = 1'b1;
                        w_mem_we_nxt    = w_sel_we;
                        w_mem_addr_nxt  = {w_sel_addr[ADDR_W-1:2], 2'b00};
                        w_mem_be_nxt    = w_grant_d ? store_be(bus.d_wr_ctrl, bus.d_addr[1:0]) : 4'b0000;
                        w_mem_wdata_nxt = w_grant_d ? store_data(bus.d_wr_ctrl, bus.d_wdata) : 32'h0;
                    end
                end
            end
            ST_ISSUE: begin
                if (bus.mem_gnt) begin
                    w_mem_req_nxt   = 1'b0;
                    w_mem_we_nxt    = 1'b0;
                    w_mem_addr_nxt  = '0;
                    w_mem_be_nxt    = 4'b0000;
                    w_mem_wdata_nxt = 32'h0;
                    w_state_nxt     = r_we ? ST_IDLE : ST_WAIT_RD;
                end
            end
            ST_WAIT_RD: begin
                if (bus.mem_rvalid) begin
                    w_state_nxt = ST_IDLE;
                    if (r_owner_d) begin
                        w_d_ack_nxt   = 1'b1;
                        w_d_rdata_nxt = w_load_data;
                    end else begin
                        w_if_ack_nxt   = 1'b1;
                        w_if_rdata_nxt = bus.mem_rdata;
                    end
                end
            end
            ST_ERR_RESP: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_last_d    <= 1'b0;
            r_owner_d   <= 1'b0;
            r_we        <= 1'b0;
            r_addr_lo   <= 2'b00;
            r_rd_ctrl   <= RD_NONE;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_be    <= 4'b0000;
            r_mem_wdata <= 32'h0;
            r_if_ack    <= 1'b0;
            r_if_rdata  <= 32'h0;
            r_if_err    <= 1'b0;
            r_d_ack     <= 1'b0;
            r_d_rdata   <= 32'h0;
            r_d_err     <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_last_d    <= w_last_d_nxt;
            r_owner_d   <= w_owner_d_nxt;
            r_we        <= w_we_nxt;
            r_addr_lo   <= w_addr_lo_nxt;
            r_rd_ctrl   <= w_rd_ctrl_nxt;
            r_mem_req   <= w_mem_req_nxt;
            r_mem_we    <= w_mem_we_nxt;
            r_mem_addr  <= w_mem_addr_nxt;
            r_mem_be    <= w_mem_be_nxt;
            r_mem_wdata <= w_mem_wdata_nxt;
            r_if_ack    <= w_if_ack_nxt;
            r_if_rdata  <= w_if_rdata_nxt;
            r_if_err    <= w_if_err_nxt;
            r_d_ack     <= w_d_ack_nxt;
            r_d_rdata   <= w_d_rdata_nxt;
            r_d_err     <= w_d_err_nxt;
        end
    end

    assign bus.mem_req   = r_mem_req;
    assign bus.mem_we    = r_mem_we;
    assign bus.mem_addr  = r_mem_addr;
    assign bus.mem_be    = r_mem_be;
    assign bus.mem_wdata = r_mem_wdata;
    assign bus.if_ack    = r_if_ack;
    assign bus.if_rdata  = r_if_rdata;
    assign bus.if_err    = r_if_err;
    assign bus.d_ack     = r_d_ack | w_wr_ack;
    assign bus.d_rdata   = r_d_rdata;
    assign bus.d_err     = r_d_err;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - Scoreboarded directed test of mem_port_arbiter
module tb_mem_port_arbiter;
    import cpu_pkg::*;

    typedef struct { bit is_d; logic [31:0] rdata; bit err; } rsp_t;
    typedef struct { bit we; logic [31:0] addr; logic [3:0] be; logic [31:0] wdata; } acc_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mem_port_arbiter_if #(.ADDR_W(32)) bus ();
    mem_port_arbiter #(.ADDR_W(32)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    rsp_t rsp_q[$];
    acc_t acc_q[$];
    logic [31:0] mem_words [logic [31:0]];
    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int gnt_delay = 0;
    int grants = 0;
    int acks = 0;
    bit suppress_rd = 1'b0;
    bit stale_rvalid = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk_outputs_zero(input string pfx);
        chk1({pfx, "_mem_req"}, bus.mem_req, 1'b0);
        chk1({pfx, "_mem_we"}, bus.mem_we, 1'b0);
        chk({pfx, "_mem_addr"}, bus.mem_addr, 32'h0);
        chk({pfx, "_mem_be"}, {28'h0, bus.mem_be}, 32'h0);
        chk({pfx, "_mem_wdata"}, bus.mem_wdata, 32'h0);
        chk1({pfx, "_if_ack"}, bus.if_ack, 1'b0);
        chk({pfx, "_if_rdata"}, bus.if_rdata, 32'h0);
        chk1({pfx, "_if_err"}, bus.if_err, 1'b0);
        chk1({pfx, "_d_ack"}, bus.d_ack, 1'b0);
        chk({pfx, "_d_rdata"}, bus.d_rdata, 32'h0);
        chk1({pfx, "_d_err"}, bus.d_err, 1'b0);
    endtask

    // Memory model: checks each issued access against the expected-access queue, grants after gnt_delay, returns read data next cycle
    initial begin : mem_model
        acc_t e;
        int wcnt;
        bit pend;
        logic [31:0] raddr;
        wcnt = 0; pend = 1'b0; raddr = 32'h0;
        bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b0; bus.mem_rdata = 32'h0;
        forever begin
            @(negedge clk);
            bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b0; bus.mem_rdata = 32'h0;
            if (!rst_n) begin
                wcnt = 0; pend = 1'b0;
                continue;
            end
            if (pend && !suppress_rd) begin
                bus.mem_rvalid = 1'b1;
                bus.mem_rdata = mem_words.exists(raddr) ? mem_words[raddr] : 32'h0;
            end else if (stale_rvalid) begin
                bus.mem_rvalid = 1'b1;
                bus.mem_rdata = 32'hBAD0_BAD0;
            end
            pend = 1'b0;
            if (bus.mem_req) begin
                checks++;
                assert (acc_q.size() != 0) else begin
                    errors++;
                    $error("FAIL unexpected_mem_req: observed mem_req=1 addr=0x%08h expected no access", bus.mem_addr);
                end
                if (acc_q.size() != 0) begin
                    e = acc_q[0];
                    chk1("mem_we", bus.mem_we, e.we);
                    chk("mem_addr", bus.mem_addr, e.addr);
                    chk("mem_be", {28'h0, bus.mem_be}, {28'h0, e.be});
                    if (e.we) chk("mem_wdata", bus.mem_wdata, e.wdata);
                end else begin
                    e = '{bus.mem_we, bus.mem_addr, 4'h0, 32'h0};
                end
                if (wcnt >= gnt_delay) begin
                    bus.mem_gnt = 1'b1;
                    grants++;
                    wcnt = 0;
                    if (acc_q.size() != 0) void'(acc_q.pop_front());
                    if (!e.we) begin
                        pend = 1'b1;
                        raddr = e.addr;
                    end
                end else begin
                    wcnt++;
                end
            end
        end
    end

    // Ack monitor: every ack is matched against the next expected response in order
    initial begin : ack_monitor
        rsp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (bus.if_ack || bus.d_ack) begin
                acks++;
                chk1("ack_exclusive", bus.if_ack & bus.d_ack, 1'b0);
                checks++;
                assert (rsp_q.size() != 0) else begin
                    errors++;
                    $error("FAIL unexpected_ack: observed if_ack=%b d_ack=%b expected none", bus.if_ack, bus.d_ack);
                end
                if (rsp_q.size() != 0) begin
                    e = rsp_q.pop_front();
                    chk1("ack_owner_d", bus.d_ack, e.is_d);
                    chk("ack_rdata", e.is_d ? bus.d_rdata : bus.if_rdata, e.rdata);
                    chk1("ack_err", e.is_d ? bus.d_err : bus.if_err, e.err);
                end
            end
        end
    end

    task automatic wait_ack(input bit is_d, input int c0, output int lat);
        lat = -1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            #3;
            if (is_d ? bus.d_ack : bus.if_ack) begin
                lat = cyc - c0;
                break;
            end
        end
        chk1("ack_seen", lat >= 0, 1'b1);
    endtask

    task automatic d_txn(input logic [31:0] a, input logic [2:0] rd, input logic [1:0] wr,
                         input logic [31:0] wd, input logic [31:0] exp_rd, input bit exp_err,
                         input logic [3:0] exp_be, input logic [31:0] exp_wd, output int lat);
        int c0;
        rsp_q.push_back('{1'b1, exp_rd, exp_err});
        if (!exp_err) acc_q.push_back('{(wr != WR_NONE), a & 32'hFFFF_FFFC, exp_be, exp_wd});
        @(negedge clk);
        bus.d_addr = a; bus.d_rd_ctrl = rd; bus.d_wr_ctrl = wr; bus.d_wdata = wd; bus.d_req = 1'b1;
        c0 = cyc;
        wait_ack(1'b1, c0, lat);
        bus.d_req = 1'b0;
    endtask

    task automatic f_txn(input logic [31:0] a, input logic [31:0] exp_rd, input bit exp_err, output int lat);
        int c0;
        rsp_q.push_back('{1'b0, exp_rd, exp_err});
        if (!exp_err) acc_q.push_back('{1'b0, a & 32'hFFFF_FFFC, 4'h0, 32'h0});
        @(negedge clk);
        bus.if_addr = a; bus.if_req = 1'b1;
        c0 = cyc;
        wait_ack(1'b0, c0, lat);
        bus.if_req = 1'b0;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b1;
    endtask

    initial begin : stimulus
        int lat, g0, a0, nd, nf;
        bus.if_req = 1'b0; bus.if_addr = 32'h0;
        bus.d_req = 1'b0; bus.d_addr = 32'h0; bus.d_rd_ctrl = RD_NONE; bus.d_wr_ctrl = WR_NONE; bus.d_wdata = 32'h0;
        mem_words[32'h100] = 32'h0050_0093;
        mem_words[32'h200] = 32'h8081_F2F3;

        repeat (3) @(negedge clk);
        #1 chk_outputs_zero("reset");
        rst_n = 1'b1;

        f_txn(32'h100, 32'h0050_0093, 1'b0, lat);
        chk("fetch_latency", lat, 3);

        d_txn(32'h201, RD_LB,  WR_NONE, 32'h0, 32'hFFFF_FFF2, 1'b0, 4'h0, 32'h0, lat);
        chk("load_latency", lat, 3);
        d_txn(32'h201, RD_LBU, WR_NONE, 32'h0, 32'h0000_00F2, 1'b0, 4'h0, 32'h0, lat);
        d_txn(32'h202, RD_LH,  WR_NONE, 32'h0, 32'hFFFF_8081, 1'b0, 4'h0, 32'h0, lat);
        d_txn(32'h202, RD_LHU, WR_NONE, 32'h0, 32'h0000_8081, 1'b0, 4'h0, 32'h0, lat);
        d_txn(32'h200, RD_LW,  WR_NONE, 32'h0, 32'h8081_F2F3, 1'b0, 4'h0, 32'h0, lat);

        d_txn(32'h103, RD_NONE, WR_SB, 32'hDEAD_BEEF, 32'h0, 1'b0, 4'b1000, 32'hEFEF_EFEF, lat);
        d_txn(32'h102, RD_NONE, WR_SH, 32'hDEAD_BEEF, 32'h0, 1'b0, 4'b1100, 32'hBEEF_BEEF, lat);
        d_txn(32'h100, RD_NONE, WR_SW, 32'hDEAD_BEEF, 32'h0, 1'b0, 4'b1111, 32'hDEAD_BEEF, lat);
        chk("store_latency", lat, 1);

        g0 = grants;
        d_txn(32'h202, RD_LW,   WR_NONE, 32'h0, 32'h0, 1'b1, 4'h0, 32'h0, lat);
        chk("err_lw_latency", lat, 1);
        d_txn(32'h101, RD_NONE, WR_SH,   32'h0, 32'h0, 1'b1, 4'h0, 32'h0, lat);
        d_txn(32'h200, RD_LH,   WR_SB,   32'h0, 32'h0, 1'b1, 4'h0, 32'h0, lat);
        d_txn(32'h200, 3'd6,    WR_NONE, 32'h0, 32'h0, 1'b1, 4'h0, 32'h0, lat);
        d_txn(32'h200, RD_NONE, WR_NONE, 32'h0, 32'h0, 1'b1, 4'h0, 32'h0, lat);
        f_txn(32'h102, 32'h0, 1'b1, lat);
        chk("err_fetch_latency", lat, 1);
        chk("err_no_grants", grants, g0);

        apply_reset();
        gnt_delay = 3;
        rsp_q.push_back('{1'b1, 32'h8081_F2F3, 1'b0});
        rsp_q.push_back('{1'b0, 32'h0050_0093, 1'b0});
        rsp_q.push_back('{1'b1, 32'h8081_F2F3, 1'b0});
        rsp_q.push_back('{1'b0, 32'h0050_0093, 1'b0});
        acc_q.push_back('{1'b0, 32'h200, 4'h0, 32'h0});
        acc_q.push_back('{1'b0, 32'h100, 4'h0, 32'h0});
        acc_q.push_back('{1'b0, 32'h200, 4'h0, 32'h0});
        acc_q.push_back('{1'b0, 32'h100, 4'h0, 32'h0});
        @(negedge clk);
        bus.d_addr = 32'h200; bus.d_rd_ctrl = RD_LW; bus.d_wr_ctrl = WR_NONE; bus.d_req = 1'b1;
        bus.if_addr = 32'h100; bus.if_req = 1'b1;
        nd = 0; nf = 0;
        for (int i = 0; i < 200 && (nd < 2 || nf < 2); i++) begin
            @(negedge clk);
            #3;
            if (bus.d_ack) begin nd++; if (nd == 2) bus.d_req = 1'b0; end
            if (bus.if_ack) begin nf++; if (nf == 2) bus.if_req = 1'b0; end
        end
        bus.d_req = 1'b0; bus.if_req = 1'b0;
        chk("cont_d_acks", nd, 2);
        chk("cont_f_acks", nf, 2);
        gnt_delay = 0;

        suppress_rd = 1'b1;
        acc_q.push_back('{1'b0, 32'h100, 4'h0, 32'h0});
        g0 = grants;
        @(negedge clk);
        bus.if_addr = 32'h100; bus.if_req = 1'b1;
        for (int i = 0; i < 20 && grants == g0; i++) begin
            @(negedge clk);
            #1;
        end
        chk("rst_fetch_granted", grants, g0 + 1);
        @(negedge clk);
        #1 rst_n = 1'b0;
        bus.if_req = 1'b0;
        #1 chk_outputs_zero("midrst");
        a0 = acks;
        @(negedge clk);
        #1 rst_n = 1'b1;
        suppress_rd = 1'b0;
        stale_rvalid = 1'b1;
        @(negedge clk);
        #1 stale_rvalid = 1'b0;
        repeat (3) @(negedge clk);
        chk("stale_rvalid_no_ack", acks, a0);
        f_txn(32'h100, 32'h0050_0093, 1'b0, lat);
        chk("post_reset_fetch_latency", lat, 3);

        repeat (3) @(negedge clk);
        chk("rsp_q_drained", rsp_q.size(), 0);
        chk("acc_q_drained", acc_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
